// File: rtl/fifo_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_pkg
// Shared definitions for the FIFO-fed UART transmitter:
//   - state_t           : transmitter FSM state encoding
//   - DEFAULT_DBITS     : default data word width
//   - DEFAULT_CLKS_PER_BIT : default SYS_CLK cycles per serial bit
//   - cntWidth()        : width needed to hold values 0 .. n-1
// ---------------------------------------------------------------------------
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DEFAULT_DBITS        = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Counter width for a range 0 .. n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// ---------------------------------------------------------------------------
// baud_tick
// Free-running bit-period counter. tick_o is high during the last SYS_CLK
// cycle of each bit period; restart_i forces the count back to zero on the
// next edge so every FSM state starts with a full bit period.
// Ports:
//   SYS_CLK    in  system clock
//   reset      in  asynchronous, active-high reset
//   restart_i  in  restart the bit period from zero
//   tick_o     out end-of-bit pulse
// ---------------------------------------------------------------------------
module baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic SYS_CLK,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = cntWidth(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count up and wrap at the end of each bit; a restart wins over counting.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Bit-period counter register.
  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// UART transmitter that pulls words from an external FIFO and sends them as
// start / DBITS data (LSB first) / optional even parity / stop frames.
// Ports:
//   SYS_CLK     in  system clock, rising edge
//   reset       in  asynchronous, active-high reset
//   enable      in  allows a new frame to start
//   fifo_empty  in  FIFO empty flag
//   fifo_rd     out one-cycle pop strobe
//   fifo_dout   in  FIFO data, valid the cycle after fifo_rd
//   tx          out registered serial line, idle high
//   busy        out high from the pop cycle through the last stop cycle
//   frame_done  out pulse on the final cycle of the stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DBITS        = DEFAULT_DBITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1
) (
  input  logic             SYS_CLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = cntWidth(DBITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DBITS - 1);

  state_t           state_q, state_d;
  logic [DBITS-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             ready_q;
  logic             tick;
  logic             restart;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .SYS_CLK   (SYS_CLK),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Next-state logic. The line value is derived from the state and shift
  // register the FSM is about to be in, so tx can be registered without
  // lagging the state by a cycle.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    parity_d = parity_q;
    tx_d     = 1'b1;

    case (state_q)
      IDLE: begin
        // ready_q holds off the first pop until one edge after reset release
        if (ready_q && enable && !fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d  = fifo_dout;
        parity_d = ^fifo_dout;
        state_d  = START;
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase

    restart = (state_d != state_q);
  end

  // State, datapath and line registers.
  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= 1'b1;
    end
  end

  assign fifo_rd    = (state_q == POP);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && tick;
  assign tx         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Self-checking bench: a queue-based FIFO model feeds the DUT, a scoreboard
// holds the words expected on the line, and a monitor rebuilds each frame
// from tx and compares it against the scoreboard.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB          = 4;
  localparam int NBITS        = 8;
  localparam int FRAME_BITS   = 11;
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic             SYS_CLK = 1'b0;
  logic             reset;
  logic             enable;
  logic             fifo_empty = 1'b1;
  logic             fifo_rd;
  logic [NBITS-1:0] fifo_dout = '0;
  logic             tx;
  logic             busy;
  logic             frame_done;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int rdCount = 0;
  int rdRun = 0;
  int maxRun = 0;
  int framesDone = 0;
  int startsSeen = 0;
  int startLast = 0;
  int startPrev = 0;

  logic [NBITS-1:0] fifoQ[$];
  logic [NBITS-1:0] expQ[$];

  fifo_uart_tx #(
    .DBITS        (NBITS),
    .CLKS_PER_BIT (CPB),
    .PARITY_EN    (1)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // 10 time-unit clock period.
  always #5 SYS_CLK = ~SYS_CLK;

  // Free-running cycle counter used to timestamp frame starts.
  always @(posedge SYS_CLK) cyc <= cyc + 1;

  // FIFO model: a pop presents its word on fifo_dout the following cycle.
  always @(posedge SYS_CLK) begin
    if (fifo_rd && fifoQ.size() > 0) begin
      fifo_dout <= fifoQ.pop_front();
    end
    fifo_empty <= (fifoQ.size() == 0);
  end

  // Pop strobe bookkeeping: total pulses and longest run of consecutive highs.
  always @(negedge SYS_CLK) begin
    if (fifo_rd) begin
      rdCount = rdCount + 1;
      rdRun   = rdRun + 1;
      if (rdRun > maxRun) maxRun = rdRun;
    end else begin
      rdRun = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue a word into the FIFO model and the scoreboard together.
  task automatic applyStimulus(input logic [NBITS-1:0] word);
    fifoQ.push_back(word);
    expQ.push_back(word);
  endtask

  // Line image of one frame, index 0 sent first.
  function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [NBITS-1:0] word);
    logic [FRAME_BITS-1:0] f;
    f[0]           = 1'b0;
    f[NBITS:1]     = word;
    f[NBITS+1]     = ^word;
    f[NBITS+2]     = 1'b1;
    return f;
  endfunction

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (framesDone < target && n < budget) begin
      @(negedge SYS_CLK);
      n++;
    end
    checkOutput("frameTimeout", 32'(framesDone >= target), 32'd1);
  endtask

  task automatic waitStarts(input int target, input int budget);
    int n = 0;
    while (startsSeen < target && n < budget) begin
      @(negedge SYS_CLK);
      n++;
    end
    checkOutput("startTimeout", 32'(startsSeen >= target), 32'd1);
  endtask

  // Monitor: on a falling tx edge, sample every cycle of the frame, rebuild
  // the bit image and compare against the oldest scoreboard entry.
  initial begin : monitor
    logic                  prevTx;
    logic [FRAME_BITS-1:0] obs;
    logic                  glitch;
    logic                  aborted;
    int                    doneCnt;
    int                    doneAt;
    int                    busyLow;
    logic [NBITS-1:0]      expWord;
    prevTx = 1'b1;
    forever begin
      @(negedge SYS_CLK);
      if (!reset && tx == 1'b0 && prevTx == 1'b1) begin
        startPrev  = startLast;
        startLast  = cyc;
        startsSeen = startsSeen + 1;
        obs = '0; glitch = 1'b0; aborted = 1'b0;
        doneCnt = 0; doneAt = -1; busyLow = 0;
        for (int k = 0; k < FRAME_CYCLES; k++) begin
          if (k != 0) @(negedge SYS_CLK);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) obs[k / CPB] = tx;
          else if (tx != obs[k / CPB]) glitch = 1'b1;
          if (frame_done) begin
            doneCnt = doneCnt + 1;
            doneAt  = k;
          end
          if (!busy) busyLow = busyLow + 1;
        end
        prevTx = 1'b1;
        if (!aborted) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedFrame", 32'd1, 32'd0);
          end else begin
            expWord = expQ.pop_front();
            checkOutput("frameBits", 32'(obs), 32'(buildFrame(expWord)));
          end
          checkOutput("bitGlitch", 32'(glitch), 32'd0);
          checkOutput("doneCount", 32'(doneCnt), 32'd1);
          checkOutput("doneLastCycle", 32'(doneAt), 32'(FRAME_CYCLES - 1));
          checkOutput("busyInFrame", 32'(busyLow), 32'd0);
          framesDone = framesDone + 1;
        end
      end else begin
        prevTx = reset ? 1'b1 : tx;
      end
    end
  end

  initial begin : stimulus
    int rd0;
    int s0;
    int f0;
    int bad;
    reset  = 1'b1;
    enable = 1'b0;

    // Reset state, with 0xA5 already waiting in the FIFO.
    applyStimulus(8'hA5);
    enable = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    checkOutput("rstTx", 32'(tx), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstRd", 32'(fifo_rd), 32'd0);
    checkOutput("rstDone", 32'(frame_done), 32'd0);
    rd0 = rdCount;
    reset = 1'b0;
    @(negedge SYS_CLK);
    checkOutput("firstEdgeRd", 32'(fifo_rd), 32'd0);

    // Single 0xA5 frame.
    waitFrames(1, 200);
    checkOutput("t1Pops", 32'(rdCount - rd0), 32'd1);

    // Back-to-back 0x01, 0x80.
    rd0 = rdCount;
    applyStimulus(8'h01);
    applyStimulus(8'h80);
    waitFrames(3, 300);
    checkOutput("t2Pops", 32'(rdCount - rd0), 32'd2);
    checkOutput("t2StartSpacing", 32'(startLast - startPrev), 32'(FRAME_CYCLES + 3));

    // Empty FIFO with enable high: the line must stay idle.
    bad = 0;
    repeat (100) begin
      @(negedge SYS_CLK);
      if (fifo_rd || !tx || busy) bad++;
    end
    checkOutput("t3Idle", 32'(bad), 32'd0);

    // Drop enable during data bit 3 of 0x3C while 0x55 waits behind it.
    rd0 = rdCount;
    s0  = startsSeen;
    f0  = framesDone;
    applyStimulus(8'h3C);
    applyStimulus(8'h55);
    waitStarts(s0 + 1, 50);
    repeat (17) @(negedge SYS_CLK);
    enable = 1'b0;
    waitFrames(f0 + 1, 100);
    repeat (30) @(negedge SYS_CLK);
    checkOutput("t4HeldPops", 32'(rdCount - rd0), 32'd1);
    checkOutput("t4HeldStarts", 32'(startsSeen - s0), 32'd1);
    enable = 1'b1;
    waitFrames(f0 + 2, 100);
    checkOutput("t4Pops", 32'(rdCount - rd0), 32'd2);

    // Reset in cycle 20 of a 0x96 frame; 0x5A must follow as a clean frame.
    rd0 = rdCount;
    s0  = startsSeen;
    f0  = framesDone;
    applyStimulus(8'h96);
    applyStimulus(8'h5A);
    waitStarts(s0 + 1, 50);
    repeat (19) @(negedge SYS_CLK);
    #1 reset = 1'b1;
    #1;
    checkOutput("t5RstTx", 32'(tx), 32'd1);
    checkOutput("t5RstBusy", 32'(busy), 32'd0);
    checkOutput("t5RstDone", 32'(frame_done), 32'd0);
    void'(expQ.pop_front());
    repeat (3) @(negedge SYS_CLK);
    reset = 1'b0;
    @(negedge SYS_CLK);
    checkOutput("t5FirstEdgeRd", 32'(fifo_rd), 32'd0);
    waitFrames(f0 + 1, 100);
    checkOutput("t5Pops", 32'(rdCount - rd0), 32'd2);

    repeat (5) @(negedge SYS_CLK);
    checkOutput("rdPulseWidth", 32'(maxRun), 32'd1);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
